// File: rtl/mem_access_unit.sv
// Memory access stage: pass, load, store and swap against a
// combinational-read data memory, with valid/ready on both sides.
module mem_access_unit #(
    parameter int BUS_WIDTH      = 8,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      exValid,
    output logic                      exReady,
    input  logic [1:0]                exOp,
    input  logic [BUS_WIDTH-1:0]      exAddress,
    input  logic [BUS_WIDTH-1:0]      exData,
    input  logic [REG_ADDR_WIDTH-1:0] exDestReg,
    output logic [BUS_WIDTH-1:0]      memAddress,
    output logic [BUS_WIDTH-1:0]      memData,
    output logic                      memWrite,
    input  logic [BUS_WIDTH-1:0]      memReadData,
    output logic                      wbValid,
    input  logic                      wbReady,
    output logic [BUS_WIDTH-1:0]      wbData,
    output logic [REG_ADDR_WIDTH-1:0] wbDestReg,
    output logic                      wbWriteEnable
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        HOLD
    } state_t;

    localparam logic [1:0] OP_PASS  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    state_t                      state_q, state_d;
    logic [1:0]                  op_q;
    logic [BUS_WIDTH-1:0]        addr_q;
    logic [BUS_WIDTH-1:0]        data_q;
    logic [BUS_WIDTH-1:0]        wbdata_q, wbdata_d;
    logic [REG_ADDR_WIDTH-1:0]   dest_q;
    logic                        we_q;
    logic                        accept;

    assign accept = exValid && exReady;

    always_comb begin
        state_d  = state_q;
        wbdata_d = wbdata_q;
        exReady  = 1'b0;
        wbValid  = 1'b0;
        memWrite = 1'b0;
        unique case (state_q)
            IDLE: begin
                exReady = 1'b1;
                if (exValid) begin
                    // Pass and store retire exData; load/swap overwrite it in READ
                    wbdata_d = exData;
                    unique case (exOp)
                        OP_PASS:  state_d = HOLD;
                        OP_LOAD:  state_d = READ;
                        OP_STORE: state_d = WRITE;
                        OP_SWAP:  state_d = READ;
                        default:  state_d = IDLE;
                    endcase
                end
            end
            READ: begin
                wbdata_d = memReadData;
                state_d  = (op_q == OP_SWAP) ? WRITE : HOLD;
            end
            WRITE: begin
                memWrite = 1'b1;
                state_d  = HOLD;
            end
            HOLD: begin
                wbValid = 1'b1;
                if (wbReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_PASS;
            addr_q   <= '0;
            data_q   <= '0;
            wbdata_q <= '0;
            dest_q   <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wbdata_q <= wbdata_d;
            if (accept) begin
                op_q   <= exOp;
                addr_q <= exAddress;
                data_q <= exData;
                dest_q <= exDestReg;
                we_q   <= (exOp != OP_STORE);
            end
        end
    end

    assign memAddress    = addr_q;
    assign memData       = data_q;
    assign wbData        = wbdata_q;
    assign wbDestReg     = dest_q;
    assign wbWriteEnable = we_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The module SHALL have parameter BUS_WIDTH, default 8, giving the data and address width.
REQ-002 The module SHALL have parameter REG_ADDR_WIDTH, default 3, giving the destination-register tag width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port exValid, input, 1 bit: the execute stage offers a transaction.
REQ-006 The module SHALL have port exReady, output, 1 bit: the unit accepts a transaction this cycle.
REQ-007 The module SHALL have port exOp, input, 2 bits: 00 pass, 01 load, 10 store, 11 swap.
REQ-008 The module SHALL have port exAddress, input, BUS_WIDTH bits: the memory address.
REQ-009 The module SHALL have port exData, input, BUS_WIDTH bits: the store data, or the pass-through result.
REQ-010 The module SHALL have port exDestReg, input, REG_ADDR_WIDTH bits: the writeback register tag.
REQ-011 The module SHALL have port memAddress, output, BUS_WIDTH bits: the address to data memory.
REQ-012 The module SHALL have port memData, output, BUS_WIDTH bits: the write data to data memory.
REQ-013 The module SHALL have port memWrite, output, 1 bit: data-memory readWriteControl (1 = write, 0 = read).
REQ-014 The module SHALL have port memReadData, input, BUS_WIDTH bits: the data-memory read output, which is combinational.
REQ-015 The module SHALL have port wbValid, output, 1 bit: a result is presented to writeback.
REQ-016 The module SHALL have port wbReady, input, 1 bit: writeback consumes the result.
REQ-017 The module SHALL have port wbData, output, BUS_WIDTH bits: the result data.
REQ-018 The module SHALL have port wbDestReg, output, REG_ADDR_WIDTH bits: the result register tag.
REQ-019 The module SHALL have port wbWriteEnable, output, 1 bit: 1 = write the register file, 0 = store retirement only.

Function
REQ-020 The FSM SHALL have states IDLE, READ, WRITE, and HOLD.
REQ-021 The unit SHALL drive exReady = 1 only in IDLE; a transaction is accepted when exValid && exReady at a clock edge.
REQ-022 On acceptance, the unit SHALL register exOp, exAddress, exData, and exDestReg.
REQ-023 The unit SHALL ignore exAddress, exData, exOp, and exDestReg outside of acceptance.
REQ-024 On acceptance, the next state SHALL be: pass -> HOLD; load -> READ; store -> WRITE; swap -> READ.
REQ-025 In READ, memWrite SHALL be 0, and memReadData SHALL be captured into wbData at the end of the cycle.
REQ-026 From READ, the next state SHALL be HOLD for a load, and WRITE for a swap.
REQ-027 In WRITE, memWrite SHALL be 1 for exactly one cycle, and the next state SHALL be HOLD.
REQ-028 memWrite SHALL be 0 in every state other than WRITE.
REQ-029 memAddress and memData SHALL be driven from registers, stable for the whole READ/WRITE cycle, with no combinational path from ex* inputs.
REQ-030 memData SHALL equal the registered exData; memAddress SHALL equal the registered exAddress, with no modification (8-bit space, no wrap logic).
REQ-031 In HOLD, wbValid SHALL be 1, and wbData, wbDestReg, and wbWriteEnable SHALL be held stable until wbReady = 1; then the next state SHALL be IDLE.
REQ-032 wbData SHALL be exData for pass, the read data for load and swap (the old memory contents), and the registered exData for store.
REQ-033 wbWriteEnable SHALL be 1 for pass, load, and swap, and 0 for store.
REQ-034 Latency from acceptance edge to wbValid = 1 SHALL be: pass 1, load 2, store 2, swap 3 cycles.
REQ-035 With wbReady held at 1, the unit SHALL accept a new transaction on the cycle after the HOLD handshake (one IDLE cycle minimum).
REQ-036 wbValid SHALL be 0 outside HOLD; exValid while busy SHALL be stalled, not dropped.

Reset
REQ-037 While rst = 1, the state SHALL be IDLE, and memWrite, wbValid, wbWriteEnable, memAddress, memData, wbData, and wbDestReg SHALL be 0; exReady SHALL be 1 after rst deasserts.
REQ-038 rst asserted mid-transaction SHALL immediately force memWrite to 0 (asynchronously) and SHALL discard the transaction, with no writeback.

Verification
REQ-039 Store then load: store 0x5A to 0x10, then load 0x10 -> memWrite pulses 1 cycle at address 0x10; the load returns wbData = 0x5A, wbWriteEnable = 1, after 2 cycles.
REQ-040 Swap: mem[0x20] = 0x11, swap exData = 0x22 -> wbData = 0x11 after 3 cycles; a following load of 0x20 returns 0x22.
REQ-041 Backpressure: hold wbReady = 0 for 5 cycles after a pass of 0x7E -> wbValid stays 1 and wbData stays 0x7E; exReady = 0 throughout; exValid stays stalled.
REQ-042 Reset during a swap: assert rst in WRITE -> memWrite falls without a clock edge; mem[addr] keeps its old value; wbValid = 0.
REQ-043 Boundary addresses: stores to 0x00 and 0xFF with data 0xA5/0x3C -> loads return the correct values; a store retires with wbWriteEnable = 0.
